msg_deserializer: RTL and testbench

MSG_DESERIALIZER -- requirements
Module: msg_deserializer

---
 rtl/msg_deserializer.sv | 145 ++++++++++++++
 tb/tb_msg_deserializer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/msg_deserializer.sv
// Collects LANES beats of WIDTH bits into one word, with the first beat in the LSBs.
// Define MSG_DESERIALIZER_FLUSH_EN to add the flush input and the send_mask output for partial words.
module msg_deserializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       recv_msg,
  input  logic                   recv_val,
  output logic                   recv_rdy,
  output logic [WIDTH*LANES-1:0] send_msg,
  output logic                   send_val,
  input  logic                   send_rdy
`ifdef MSG_DESERIALIZER_FLUSH_EN
  ,
  input  logic                   flush,
  output logic [LANES-1:0]       send_mask
`endif
);

  localparam int unsigned IDXW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

  typedef enum logic {FILL, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [WIDTH*LANES-1:0] data_q, data_d;
`ifdef MSG_DESERIALIZER_FLUSH_EN
  logic [LANES-1:0]       mask_q, mask_d;
`endif

  logic recv_xfer;
  logic send_xfer;

  assign recv_xfer = recv_val && recv_rdy;
  assign send_xfer = send_val && send_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      data_q  <= '0;
`ifdef MSG_DESERIALIZER_FLUSH_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
`ifdef MSG_DESERIALIZER_FLUSH_EN
      mask_q  <= mask_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
`ifdef MSG_DESERIALIZER_FLUSH_EN
    mask_d  = mask_q;
`endif
    unique case (state_q)
      FILL: begin
        if (recv_xfer) begin
          data_d[idx_q*WIDTH +: WIDTH] = recv_msg;
`ifdef MSG_DESERIALIZER_FLUSH_EN
          mask_d[idx_q] = 1'b1;
`endif
          if (idx_q == LAST_IDX) begin
            state_d = HOLD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDXW'(1);
`ifdef MSG_DESERIALIZER_FLUSH_EN
            if (flush) begin
              state_d = HOLD;
              idx_d   = '0;
            end
`endif
          end
        end
`ifdef MSG_DESERIALIZER_FLUSH_EN
        else if (flush && (idx_q != '0)) begin
          state_d = HOLD;
          idx_d   = '0;
        end
`endif
      end
      HOLD: begin
        // A beat can only land here together with the output transfer, since recv_rdy follows send_rdy.
        if (send_xfer) begin
`ifdef MSG_DESERIALIZER_FLUSH_EN
          mask_d = '0;
`endif
          if (recv_xfer) begin
            data_d[0 +: WIDTH] = recv_msg;
`ifdef MSG_DESERIALIZER_FLUSH_EN
            mask_d[0] = 1'b1;
`endif
            if (LANES == 1) begin
              state_d = HOLD;
              idx_d   = '0;
            end else begin
              state_d = FILL;
              idx_d   = IDXW'(1);
            end
          end else begin
            state_d = FILL;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    recv_rdy = reset;
    send_val = 1'b0;
    if (state_q == HOLD) begin
      recv_rdy = send_rdy;
      send_val = 1'b1;
    end
  end

`ifdef MSG_DESERIALIZER_FLUSH_EN
  // Lanes not written in the current word keep stale data internally, so they are masked off here.
  always_comb begin
    send_msg = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      send_msg[k*WIDTH +: WIDTH] = mask_q[k] ? data_q[k*WIDTH +: WIDTH] : '0;
    end
    send_mask = send_val ? mask_q : '0;
  end
`else
  assign send_msg = data_q;
`endif

endmodule

// File: tb/tb_msg_deserializer.sv
// Directed bench for msg_deserializer (WIDTH=8, LANES=4), flush cases when MSG_DESERIALIZER_FLUSH_EN is defined.
module tb_msg_deserializer;

  logic        clk;
  logic        reset;
  logic [7:0]  recv_msg;
  logic        recv_val;
  logic        recv_rdy;
  logic [31:0] send_msg;
  logic        send_val;
  logic        send_rdy;
`ifdef MSG_DESERIALIZER_FLUSH_EN
  logic        flush;
  logic [3:0]  send_mask;
`endif

  int checks = 0;
  int errors = 0;

  msg_deserializer #(.WIDTH(8), .LANES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_msg (recv_msg),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .send_msg (send_msg),
    .send_val (send_val),
    .send_rdy (send_rdy)
`ifdef MSG_DESERIALIZER_FLUSH_EN
    ,
    .flush    (flush),
    .send_mask(send_mask)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] m);
    recv_val = 1'b1;
    recv_msg = m;
    step();
  endtask

  initial begin
    reset    = 1'b0;
    recv_msg = 8'h00;
    recv_val = 1'b0;
    send_rdy = 1'b0;
`ifdef MSG_DESERIALIZER_FLUSH_EN
    flush    = 1'b0;
`endif
    step();
    step();
    chk("rst_recv_rdy", recv_rdy, 0);
    chk("rst_send_val", send_val, 0);
    chk("rst_send_msg", send_msg, 0);
    reset = 1'b1;
    #1;
    chk("post_rst_recv_rdy", recv_rdy, 1);

    // Basic word
    send_rdy = 1'b1;
    beat(8'h11);
    beat(8'h22);
    beat(8'h33);
    chk("fill_no_val", send_val, 0);
    beat(8'h44);
    recv_val = 1'b0;
    chk("word1_val", send_val, 1);
    chk("word1_msg", send_msg, 32'h44332211);
    chk("hold_rdy_follows", recv_rdy, 1);
    step();
    chk("word1_drained", send_val, 0);

    // Backpressure with a waiting beat
    send_rdy = 1'b0;
    beat(8'h11);
    beat(8'h22);
    beat(8'h33);
    beat(8'h44);
    recv_msg = 8'h99;
    recv_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_recv_rdy", recv_rdy, 0);
      chk("bp_send_val", send_val, 1);
      chk("bp_send_msg", send_msg, 32'h44332211);
      step();
    end
    send_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", recv_rdy, 1);
    step();
    chk("bp_after_val", send_val, 0);
    beat(8'hA1);
    beat(8'hA2);
    beat(8'hA3);
    recv_val = 1'b0;
    chk("bp_word2_val", send_val, 1);
    chk("bp_word2_msg", send_msg, 32'hA3A2A199);
    step();
    chk("bp_word2_drained", send_val, 0);

    // Continuous stream
    for (int i = 1; i <= 12; i++) begin
      chk("stream_rdy", recv_rdy, 1);
      beat(8'(i));
      if ((i % 4) == 0) begin
        chk("stream_val", send_val, 1);
        chk("stream_msg", send_msg,
            {24'h0, 8'(i)} << 24 | {24'h0, 8'(i - 1)} << 16 | {24'h0, 8'(i - 2)} << 8 | {24'h0, 8'(i - 3)});
      end else begin
        chk("stream_gap", send_val, 0);
      end
    end
    recv_val = 1'b0;
    step();
    chk("stream_drained", send_val, 0);

    // Asynchronous reset mid-word
    beat(8'hAA);
    beat(8'hBB);
    recv_val = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_rdy", recv_rdy, 0);
    chk("async_rst_val", send_val, 0);
    chk("async_rst_msg", send_msg, 0);
    step();
    reset = 1'b1;
    beat(8'h01);
    beat(8'h02);
    beat(8'h03);
    chk("post_async_no_val", send_val, 0);
    beat(8'h04);
    recv_val = 1'b0;
    chk("post_async_val", send_val, 1);
    chk("post_async_msg", send_msg, 32'h04030201);
    step();
    chk("post_async_drained", send_val, 0);

`ifdef MSG_DESERIALIZER_FLUSH_EN
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_idx0_val", send_val, 0);
    chk("flush_idx0_mask", send_mask, 4'b0000);
    beat(8'h55);
    beat(8'h66);
    recv_val = 1'b0;
    send_rdy = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_val", send_val, 1);
    chk("flush_msg", send_msg, 32'h00006655);
    chk("flush_mask", send_mask, 4'b0011);
    send_rdy = 1'b1;
    step();
    chk("flush_drained_val", send_val, 0);
    chk("flush_drained_mask", send_mask, 4'b0000);
    flush = 1'b1;
    beat(8'h77);
    flush = 1'b0;
    recv_val = 1'b0;
    chk("flush_beat_val", send_val, 1);
    chk("flush_beat_msg", send_msg, 32'h00000077);
    chk("flush_beat_mask", send_mask, 4'b0001);
    step();
    chk("flush_beat_drained", send_val, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
